traffic_light_monitor: RTL and testbench

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

---
 rtl/tl_pkg.sv | 32 +++
 rtl/tl_lamp_checker.sv | 66 ++++++
 rtl/traffic_light_monitor.sv | 89 ++++++++
 tb/tb_traffic_light_monitor.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared lamp codes, tracked-state enum and default dwell minimums for the
// traffic light monitor.
package tl_pkg;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam int TL_YEL_MIN = 3;
  localparam int TL_GRN_MIN = 5;
  localparam int NUM_LAMPS  = 4;

  typedef enum logic [1:0] {
    ST_RED = 2'd0,
    ST_YEL = 2'd1,
    ST_GRN = 2'd2
  } lamp_state_t;

  typedef struct packed {
    logic onehot;
    logic seq;
    logic dwell;
  } lamp_err_t;

  // Only the forward cycle RED->GRN->YEL->RED is a legal change.
  function automatic logic legal_step(input lamp_state_t from, input lamp_state_t to);
    return (from == ST_RED && to == ST_GRN) ||
           (from == ST_GRN && to == ST_YEL) ||
           (from == ST_YEL && to == ST_RED);
  endfunction

endpackage

// File: rtl/tl_lamp_checker.sv
// Per-lamp checker: one-hot code, transition order and minimum dwell,
// all flags registered one cycle after the offending sample.
module tl_lamp_checker
  import tl_pkg::*;
#(
  parameter int YEL_MIN = TL_YEL_MIN,
  parameter int GRN_MIN = TL_GRN_MIN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] lamp,
  output lamp_err_t  err_d,
  output lamp_err_t  err_q
);

  localparam logic [7:0] YEL_MIN_C = 8'(YEL_MIN);
  localparam logic [7:0] GRN_MIN_C = 8'(GRN_MIN);

  lamp_state_t state_q, state_d, obs;
  logic [7:0]  dwell_q, dwell_d;
  logic        legal;

  always_comb begin
    obs   = ST_RED;
    legal = 1'b1;
    case (lamp)
      LAMP_RED: obs = ST_RED;
      LAMP_YEL: obs = ST_YEL;
      LAMP_GRN: obs = ST_GRN;
      default:  legal = 1'b0;
    endcase
  end

  // Illegal codes freeze state and dwell so the next good sample is judged
  // against the last good one.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    err_d   = '0;
    if (!legal) begin
      err_d.onehot = 1'b1;
    end else if (obs != state_q) begin
      err_d.seq   = !legal_step(state_q, obs);
      err_d.dwell = (state_q == ST_YEL && dwell_q < YEL_MIN_C) ||
                    (state_q == ST_GRN && dwell_q < GRN_MIN_C);
      state_d     = obs;
      dwell_d     = 8'd1;
    end else if (dwell_q != 8'hFF) begin
      dwell_d = dwell_q + 8'd1;
    end
  end

  // Dwell resets to 255 so the first departure after reset never flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RED;
      dwell_q <= 8'hFF;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Four-lamp intersection monitor: per-lamp checkers plus cross-lamp conflict,
// sticky error flag and saturating error-cycle counter.
module traffic_light_monitor
  import tl_pkg::*;
#(
  parameter int YEL_MIN = TL_YEL_MIN,
  parameter int GRN_MIN = TL_GRN_MIN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1,
  input  logic [2:0] light_M2,
  input  logic [2:0] light_MT,
  input  logic [2:0] light_S,
  input  logic       clr,
  output logic [3:0] err_onehot,
  output logic [3:0] err_seq,
  output logic [3:0] err_dwell,
  output logic       err_conflict,
  output logic       err_sticky,
  output logic [7:0] err_count
);

  logic [NUM_LAMPS-1:0][2:0] lamp_vec;
  lamp_err_t [NUM_LAMPS-1:0] lerr_d, lerr_q;
  logic [NUM_LAMPS-1:0]      nonred;
  logic       conflict_q, conflict_d;
  logic       sticky_q, sticky_d;
  logic [7:0] count_q, count_d;
  logic       any_err_d;

  assign lamp_vec = {light_S, light_MT, light_M2, light_M1};

  for (genvar g = 0; g < NUM_LAMPS; g++) begin : g_lamp
    tl_lamp_checker #(
      .YEL_MIN (YEL_MIN),
      .GRN_MIN (GRN_MIN)
    ) u_chk (
      .clk   (clk),
      .rst   (rst),
      .lamp  (lamp_vec[g]),
      .err_d (lerr_d[g]),
      .err_q (lerr_q[g])
    );
    assign nonred[g] = (lamp_vec[g] != LAMP_RED);
  end

  always_comb begin
    for (int i = 0; i < NUM_LAMPS; i++) begin
      err_onehot[i] = lerr_q[i].onehot;
      err_seq[i]    = lerr_q[i].seq;
      err_dwell[i]  = lerr_q[i].dwell;
    end
  end

  // Index map {S,MT,M2,M1}=[3:0]; M1 and M2 together are allowed.
  assign conflict_d = (nonred[3] && |nonred[2:0]) || (nonred[2] && nonred[1]);

  // Sticky and count follow the pulse inputs so they move with the pulses;
  // an error coincident with clr wins over the clear.
  always_comb begin
    any_err_d = conflict_d;
    for (int i = 0; i < NUM_LAMPS; i++) any_err_d = any_err_d | (|lerr_d[i]);
    if (clr) begin
      sticky_d = any_err_d;
      count_d  = {7'd0, any_err_d};
    end else begin
      sticky_d = sticky_q | any_err_d;
      count_d  = (any_err_d && count_q != 8'hFF) ? count_q + 8'd1 : count_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_q <= 1'b0;
      sticky_q   <= 1'b0;
      count_q    <= 8'd0;
    end else begin
      conflict_q <= conflict_d;
      sticky_q   <= sticky_d;
      count_q    <= count_d;
    end
  end

  assign err_conflict = conflict_q;
  assign err_sticky   = sticky_q;
  assign err_count    = count_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed scenarios plus
// randomized lamp traffic, all compared against a behavioural model.
module tb_traffic_light_monitor;

  localparam int YMIN = 3;
  localparam int GMIN = 5;
  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] light_M1 = R, light_M2 = R, light_MT = R, light_S = R;
  logic       clr = 1'b0;
  logic [3:0] err_onehot, err_seq, err_dwell;
  logic       err_conflict, err_sticky;
  logic [7:0] err_count;

  int vectors = 0;
  int miscompares = 0;

  traffic_light_monitor #(.YEL_MIN(YMIN), .GRN_MIN(GMIN)) dut (
    .clk          (clk),
    .rst          (rst),
    .light_M1     (light_M1),
    .light_M2     (light_M2),
    .light_MT     (light_MT),
    .light_S      (light_S),
    .clr          (clr),
    .err_onehot   (err_onehot),
    .err_seq      (err_seq),
    .err_dwell    (err_dwell),
    .err_conflict (err_conflict),
    .err_sticky   (err_sticky),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  // Model: position in the cycle RED(0)->GRN(1)->YEL(2)->RED, plus dwell.
  int   m_pos[4];
  int   m_dw[4];
  logic [3:0] e_oh, e_seq, e_dw;
  logic e_cf, e_st;
  int   e_cnt;

  function automatic logic [21:0] dut_vec();
    return {err_onehot, err_seq, err_dwell, err_conflict, err_sticky, err_count};
  endfunction

  function automatic logic [21:0] exp_vec();
    return {e_oh, e_seq, e_dw, e_cf, e_st, 8'(e_cnt)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_pos[i] = 0; m_dw[i] = 255; end
    e_oh = '0; e_seq = '0; e_dw = '0; e_cf = 1'b0; e_st = 1'b0; e_cnt = 0;
  endtask

  task automatic model_step();
    logic [2:0] code[4];
    logic nr[4];
    logic any;
    int idx, mn;
    code[0] = light_M1; code[1] = light_M2; code[2] = light_MT; code[3] = light_S;
    e_oh = '0; e_seq = '0; e_dw = '0;
    for (int i = 0; i < 4; i++) begin
      nr[i] = (code[i] != R);
      idx = (code[i] == R) ? 0 : (code[i] == G) ? 1 : (code[i] == Y) ? 2 : -1;
      if (idx < 0) e_oh[i] = 1'b1;
      else if (idx != m_pos[i]) begin
        e_seq[i] = (idx != (m_pos[i] + 1) % 3);
        mn = (m_pos[i] == 1) ? GMIN : (m_pos[i] == 2) ? YMIN : 0;
        e_dw[i] = (m_dw[i] < mn);
        m_pos[i] = idx;
        m_dw[i] = 1;
      end else if (m_dw[i] < 255) m_dw[i]++;
    end
    e_cf = (nr[3] && (nr[0] || nr[1] || nr[2])) || (nr[2] && nr[1]);
    any = (|e_oh) || (|e_seq) || (|e_dw) || e_cf;
    if (clr) begin
      e_cnt = any ? 1 : 0;
      e_st = any;
    end else begin
      if (any && e_cnt < 255) e_cnt++;
      e_st = e_st | any;
    end
  endtask

  task automatic apply(input logic [2:0] m1, m2, mt, s, input logic c);
    light_M1 = m1; light_M2 = m2; light_MT = mt; light_S = s; clr = c;
    @(posedge clk); #1;
    model_step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    light_M1 = R; light_M2 = R; light_MT = R; light_S = R; clr = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (dut_vec() !== 22'd0) begin
      miscompares++; $display("FAIL reset_state got=%h exp=%h", dut_vec(), 22'd0);
    end
    apply(R, R, R, R, 1'b0);
    vectors++;
    if (dut_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL reset_idle got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_legal_cycle();
    do_reset();
    for (int rep = 0; rep < 3; rep++) begin
      for (int k = 0; k < 16; k++) begin
        if (k < 5)       apply(G, G, R, R, 1'b0);
        else if (k < 8)  apply(Y, Y, R, R, 1'b0);
        else if (k < 13) apply(R, R, R, G, 1'b0);
        else             apply(R, R, R, Y, 1'b0);
        vectors++;
        if (dut_vec() !== exp_vec()) begin
          miscompares++; $display("FAIL legal_cycle rep=%0d k=%0d got=%h exp=%h", rep, k, dut_vec(), exp_vec());
        end
      end
    end
    apply(R, R, R, R, 1'b0);
    vectors++;
    if (dut_vec() !== 22'd0) begin
      miscompares++; $display("FAIL legal_cycle_end got=%h exp=%h", dut_vec(), 22'd0);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    apply(G, R, R, R, 1'b0);
    apply(G, R, R, G, 1'b0);
    vectors++;
    if ({err_conflict, err_sticky, err_count} !== {1'b1, 1'b1, 8'd1} || dut_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL conflict_pulse got=%h exp=%h", dut_vec(), exp_vec());
    end
    apply(G, R, R, R, 1'b0);
    vectors++;
    if (err_conflict !== 1'b0 || dut_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL conflict_drop got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_seq_onehot();
    do_reset();
    apply(R, R, G, R, 1'b0);
    apply(R, R, G, R, 1'b0);
    apply(R, R, R, R, 1'b0);
    vectors++;
    if (err_seq !== 4'b0100 || dut_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL seq_grn_red got=%h exp=%h", dut_vec(), exp_vec());
    end
    apply(R, 3'b011, R, R, 1'b0);
    vectors++;
    if (err_onehot !== 4'b0010 || err_seq !== 4'b0000 || dut_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL onehot_m2 got=%h exp=%h", dut_vec(), exp_vec());
    end
    apply(R, Y, R, R, 1'b0);
    vectors++;
    if (err_seq !== 4'b0010 || dut_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL seq_red_yel got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_dwell();
    do_reset();
    for (int k = 0; k < 4; k++) apply(G, R, R, R, 1'b0);
    apply(Y, R, R, R, 1'b0);
    vectors++;
    if (err_dwell !== 4'b0001 || err_seq !== 4'b0000 || dut_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL dwell_short_grn got=%h exp=%h", dut_vec(), exp_vec());
    end
    apply(Y, R, R, R, 1'b0);
    apply(R, R, R, R, 1'b0);
    vectors++;
    if (err_dwell !== 4'b0001 || dut_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL dwell_short_yel got=%h exp=%h", dut_vec(), exp_vec());
    end
    for (int k = 0; k < 5; k++) apply(G, R, R, R, 1'b0);
    apply(Y, R, R, R, 1'b0);
    vectors++;
    if (err_dwell !== 4'b0000 || dut_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL dwell_exact_grn got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 300; k++) apply(G, R, R, G, 1'b0);
    vectors++;
    if (err_count !== 8'd255 || dut_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL count_saturate got=%h exp=%h", dut_vec(), exp_vec());
    end
    apply(G, R, R, G, 1'b1);
    vectors++;
    if (err_count !== 8'd1 || err_sticky !== 1'b1 || dut_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL clr_with_err got=%h exp=%h", dut_vec(), exp_vec());
    end
    apply(G, R, R, Y, 1'b0);
    apply(G, R, R, R, 1'b1);
    vectors++;
    if (dut_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL clr_quiet got=%h exp=%h", dut_vec(), exp_vec());
    end
    apply(G, R, R, R, 1'b1);
    vectors++;
    if (err_count !== 8'd0 || err_sticky !== 1'b0 || dut_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL clr_clean got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    apply(R, R, R, G, 1'b0);
    apply(G, R, R, G, 1'b0);
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (dut_vec() !== 22'd0) begin
      miscompares++; $display("FAIL async_reset got=%h exp=%h", dut_vec(), 22'd0);
    end
    light_M1 = R; light_S = R;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    apply(R, R, R, R, 1'b0);
    apply(R, R, R, G, 1'b0);
    vectors++;
    if (err_seq !== 4'b0000 || dut_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL post_reset_grn got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic [2:0] cur[4];
    logic [2:0] legal3[3];
    int r;
    legal3[0] = R; legal3[1] = Y; legal3[2] = G;
    do_reset();
    for (int i = 0; i < 4; i++) cur[i] = R;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++) begin
        r = int'($urandom_range(0, 15));
        if (r >= 10 && r < 15) cur[i] = legal3[$urandom_range(0, 2)];
        else if (r == 15) cur[i] = 3'($urandom_range(0, 7));
      end
      apply(cur[0], cur[1], cur[2], cur[3], ($urandom_range(0, 15) == 0));
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL random n=%0d got=%h exp=%h", n, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_legal_cycle();
    test_conflict();
    test_seq_onehot();
    test_dwell();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
